// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_stage
// Description : One-deep decode stage that turns an operation type and its
//               control field into ALU opcode, flag write mask and multiply
//               flag. Multiplies hold the stage for a fixed latency before
//               the result is presented. Valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_stage #(
  parameter int                  ALUAW         = 4,
  parameter int                  FLAGS_W       = 4,
  parameter int                  CONTROL_W     = 12,
  parameter int                  U_BIT         = 3,
  parameter logic [ALUAW-1:0]    ADD_CODE      = 4'b0100,
  parameter logic [ALUAW-1:0]    SUB_CODE      = 4'b0010,
  parameter int                  MUL_CYCLES    = 4,
  parameter logic [FLAGS_W-1:0]  MUL_FLAG_MASK = 4'b1100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           optype,
  input  logic [CONTROL_W-1:0] ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALUAW-1:0]     alu_opcode,
  output logic [FLAGS_W-1:0]   flag_we,
  output logic                 mul_op
);

  // Operation type encodings
  localparam logic [1:0] c_op_data  = 2'd0;
  localparam logic [1:0] c_op_ldstr = 2'd1;
  localparam logic [1:0] c_op_mul   = 2'd2;

  // Countdown start value; the stage reaches FULL on the edge where cnt==1
  localparam logic [3:0] c_cnt_load = 4'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_FULL     = 2'd2
  } state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;

  logic [ALUAW-1:0]     w_alu_opcode;
  logic [FLAGS_W-1:0]   w_flag_we;
  logic                 w_mul_op;
  logic                 w_in_xfer;
  logic                 w_enter_wait;
  logic                 w_unused_ctrl;

  // Only a few control bits are decoded; the rest are intentionally ignored
  assign w_unused_ctrl = ^ctrl;

  // Ready in EMPTY, or in FULL when the held result is leaving this cycle
  assign in_ready = !rst &&
                    ((r_state == ST_EMPTY) || ((r_state == ST_FULL) && out_ready));

  assign w_in_xfer = in_valid && in_ready;

  // A multiply only parks in MUL_WAIT when its latency exceeds one cycle
  assign w_enter_wait = (optype == c_op_mul) && (MUL_CYCLES > 1);

  // Decode of the incoming operation; captured only on an input transfer
  always_comb begin
    w_alu_opcode = '0;
    w_flag_we    = '0;
    w_mul_op     = 1'b0;
    case (optype)
      c_op_data: begin
        w_alu_opcode = ctrl[ALUAW:1];
        w_flag_we    = ctrl[0] ? '1 : '0;
      end
      c_op_ldstr: begin
        w_alu_opcode = ctrl[U_BIT] ? ADD_CODE : SUB_CODE;
      end
      c_op_mul: begin
        w_flag_we = ctrl[0] ? MUL_FLAG_MASK : '0;
        w_mul_op  = 1'b1;
      end
      default: begin
        w_alu_opcode = ADD_CODE;
      end
    endcase
  end

  // Stage FSM with registered outputs and multiply countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_cnt      <= 4'd0;
      out_valid  <= 1'b0;
      alu_opcode <= '0;
      flag_we    <= '0;
      mul_op     <= 1'b0;
    end else if (flush) begin
      r_state    <= ST_EMPTY;
      r_cnt      <= 4'd0;
      out_valid  <= 1'b0;
      alu_opcode <= '0;
      flag_we    <= '0;
      mul_op     <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            alu_opcode <= w_alu_opcode;
            flag_we    <= w_flag_we;
            mul_op     <= w_mul_op;
            if (w_enter_wait) begin
              r_state   <= ST_MUL_WAIT;
              r_cnt     <= c_cnt_load;
              out_valid <= 1'b0;
            end else begin
              r_state   <= ST_FULL;
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state   <= ST_FULL;
            r_cnt     <= 4'd0;
            out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_FULL: begin
          if (w_in_xfer) begin
            // Result leaves and the next operation is loaded in the same edge
            alu_opcode <= w_alu_opcode;
            flag_we    <= w_flag_we;
            mul_op     <= w_mul_op;
            if (w_enter_wait) begin
              r_state   <= ST_MUL_WAIT;
              r_cnt     <= c_cnt_load;
              out_valid <= 1'b0;
            end else begin
              r_state   <= ST_FULL;
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            r_state   <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_EMPTY;
          r_cnt     <= 4'd0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_stage
// Description : Directed self-checking bench for alu_ctrl_stage: decode of
//               each operation type, multiply latency, backpressure, flush,
//               asynchronous reset and a multiply-latency sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_stage;

  localparam logic [1:0] OP_DATA  = 2'd0;
  localparam logic [1:0] OP_LDSTR = 2'd1;
  localparam logic [1:0] OP_MUL   = 2'd2;

  localparam int SWEEP [3] = '{1, 2, 15};

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  optype;
  logic [11:0] ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_opcode;
  logic [3:0]  flag_we;
  logic        mul_op;

  logic        sw_in_valid;
  logic        sw_in_ready  [3];
  logic        sw_out_valid [3];
  logic [3:0]  sw_alu       [3];
  logic [3:0]  sw_flag      [3];
  logic        sw_mul       [3];

  int n_checks = 0;
  int n_errors = 0;

  alu_ctrl_stage #(.MUL_CYCLES(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .optype     (optype),
    .ctrl       (ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_opcode (alu_opcode),
    .flag_we    (flag_we),
    .mul_op     (mul_op)
  );

  // Latency sweep instances share one multiply stimulus
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    alu_ctrl_stage #(.MUL_CYCLES(SWEEP[gi])) u_sw (
      .clk        (clk),
      .rst        (rst),
      .flush      (1'b0),
      .in_valid   (sw_in_valid),
      .in_ready   (sw_in_ready[gi]),
      .optype     (OP_MUL),
      .ctrl       (12'h001),
      .out_valid  (sw_out_valid[gi]),
      .out_ready  (1'b1),
      .alu_opcode (sw_alu[gi]),
      .flag_we    (sw_flag[gi]),
      .mul_op     (sw_mul[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop a runaway simulation
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic [11:0] c);
    in_valid = 1'b1;
    optype   = t;
    ctrl     = c;
  endtask

  initial begin
    logic seen;
    int   lat [3];

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    optype = OP_DATA; ctrl = 12'h000; sw_in_valid = 1'b0;

    // Reset values apply before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_flag_we", 32'(flag_we), 32'd0);
    check("rst_mul_op", 32'(mul_op), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_held_in_ready", 32'(in_ready), 32'd0);

    // DATA decode, accepted on the first edge after reset release
    rst = 1'b0;
    out_ready = 1'b1;
    drive(OP_DATA, 12'h01B);
    #1 check("empty_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("data_out", {out_valid, mul_op, flag_we, alu_opcode}, {1'b1, 1'b0, 4'hF, 4'hD});

    // Back-to-back load/store up then down
    drive(OP_LDSTR, 12'h008);
    #1 check("full_pass_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("ldstr_up", {out_valid, mul_op, flag_we, alu_opcode}, {1'b1, 1'b0, 4'h0, 4'b0100});
    drive(OP_LDSTR, 12'h000);
    #1 check("ldstr_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("ldstr_down", {out_valid, mul_op, flag_we, alu_opcode}, {1'b1, 1'b0, 4'h0, 4'b0010});
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_empty", 32'(out_valid), 32'd0);

    // Flag-setting multiply with a DATA op waiting behind it
    out_ready = 1'b0;
    drive(OP_MUL, 12'h001);
    @(negedge clk);
    drive(OP_DATA, 12'h005);
    for (int j = 0; j < 3; j++) begin
      #1;
      check($sformatf("mul_wait_in_ready%0d", j), 32'(in_ready), 32'd0);
      check($sformatf("mul_wait_out_valid%0d", j), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    // Backpressure: result held for five cycles, pending input not taken
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mul_hold%0d", k), {out_valid, mul_op, flag_we, alu_opcode},
            {1'b1, 1'b1, 4'b1100, 4'h0});
      check($sformatf("hold_in_ready%0d", k), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("data_after_mul", {out_valid, mul_op, flag_we, alu_opcode}, {1'b1, 1'b0, 4'hF, 4'h2});

    // Flush overrides a simultaneous transfer in FULL
    flush = 1'b1;
    drive(OP_LDSTR, 12'h008);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_full", 32'(out_valid), 32'd0);

    // Flush during a multiply wait abandons it
    drive(OP_MUL, 12'h000);
    @(negedge clk);
    in_valid = 1'b0;
    check("mulwait_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_wait_out_valid", 32'(out_valid), 32'd0);
    check("flush_wait_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("flush_no_output", 32'(seen), 32'd0);

    // Asynchronous reset while FULL
    drive(OP_DATA, 12'h01B);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("pre_rst_full", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", {out_valid, mul_op, flag_we, alu_opcode}, 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_empty", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply gives no output
    out_ready = 1'b1;
    drive(OP_MUL, 12'h001);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("rst_mul_no_output", 32'(seen), 32'd0);

    // Multiply latency sweep
    for (int i = 0; i < 3; i++) lat[i] = 0;
    sw_in_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("sweep_in_ready%0d", i), 32'(sw_in_ready[i]), 32'd1);
    @(negedge clk);
    sw_in_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      for (int i = 0; i < 3; i++)
        if (lat[i] == 0 && sw_out_valid[i]) lat[i] = cyc;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("sweep_latency_m%0d", SWEEP[i]), 32'(lat[i]), 32'(SWEEP[i]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 Parameter ALUAW, default 4: width of the ALU opcode.
REQ-002 Parameter FLAGS_W, default 4: width of the flag write-enable mask, ordered {N,Z,C,V} MSB first.
REQ-003 Parameter CONTROL_W, default 12: width of the control field.
REQ-004 Parameter U_BIT, default 3: control bit holding the load/store up/down bit.
REQ-005 Parameter ADD_CODE, default 4'b0100, and parameter SUB_CODE, default 4'b0010: ALU opcode encodings.
REQ-006 Parameter MUL_CYCLES, default 4, legal range 1..15: multiply latency in cycles.
REQ-007 Parameter MUL_FLAG_MASK, default 4'b1100: flag mask applied for a flag-setting multiply.
REQ-008 Ports: clk in 1, the single clock; rst in 1, asynchronous, active-high reset.
REQ-009 Ports: flush in 1, synchronous discard of all held or in-flight state.
REQ-010 Ports: in_valid in 1; in_ready out 1; optype in 2 (0 DATA, 1 LDSTR, 2 MUL, 3 BRANCH); ctrl in CONTROL_W.
REQ-011 Ports: out_valid out 1; out_ready in 1; alu_opcode out ALUAW; flag_we out FLAGS_W; mul_op out 1.

Function
REQ-012 An input transfer SHALL occur on a rising clk edge when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-013 DATA decode SHALL give alu_opcode=ctrl[ALUAW:1], flag_we=all ones if ctrl[0] else 0, mul_op=0.
REQ-014 LDSTR decode SHALL give alu_opcode=ADD_CODE if ctrl[U_BIT] else SUB_CODE, flag_we=0, mul_op=0.
REQ-015 MUL decode SHALL give alu_opcode=0, flag_we=MUL_FLAG_MASK if ctrl[0] else 0, mul_op=1.
REQ-016 BRANCH decode SHALL give alu_opcode=ADD_CODE, flag_we=0, mul_op=0.
REQ-017 Decoded values SHALL be captured in an output register at the input transfer, and the outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-018 The FSM SHALL have three states: EMPTY, MUL_WAIT and FULL.
REQ-019 In EMPTY: in_ready=1 and out_valid=0.
REQ-020 From EMPTY, a non-MUL transfer SHALL go to FULL, which gives a latency of 1 cycle to out_valid.
REQ-021 From EMPTY, a MUL transfer SHALL load cnt=MUL_CYCLES-1 and go to MUL_WAIT, or go directly to FULL when MUL_CYCLES=1.
REQ-022 In MUL_WAIT: in_ready=0 and out_valid=0; cnt SHALL decrement each cycle; the FSM SHALL go to FULL on the edge where cnt==1, so out_valid rises exactly MUL_CYCLES cycles after acceptance.
REQ-023 In FULL: out_valid=1 and in_ready=out_ready (combinational pass-through).
REQ-024 In FULL, simultaneous output and input transfers SHALL load the new decode: non-MUL stays FULL with no bubble; MUL goes to MUL_WAIT (or stays FULL when MUL_CYCLES=1).
REQ-025 In FULL, an output transfer with no input transfer SHALL go to EMPTY.
REQ-026 flush=1 SHALL force EMPTY and cnt=0 at the next edge, overriding any simultaneous transfer; no output transfer SHALL be counted as a result of that edge.
REQ-027 No output SHALL depend combinationally on optype or ctrl; only in_ready depends combinationally on out_ready.

Reset
REQ-028 While rst=1, asynchronously: state=EMPTY, cnt=0, out_valid=0, alu_opcode=0, flag_we=0, mul_op=0.
REQ-029 While rst=1, in_ready SHALL be 0.
REQ-030 An assertion of rst mid-multiply SHALL abandon the operation with no output.
REQ-031 The first input transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 DATA, ctrl=12'h01B, out_ready=1 -> next cycle out_valid=1, alu_opcode=4'hD, flag_we=4'hF, mul_op=0.
REQ-033 LDSTR with ctrl[3]=1, then LDSTR with ctrl[3]=0, back-to-back, out_ready=1 -> alu_opcode 4'b0100 then 4'b0010 on consecutive cycles, flag_we=0, in_ready held at 1.
REQ-034 MUL with ctrl[0]=1 and MUL_CYCLES=4 -> in_ready=0 for 3 cycles; out_valid=1 on cycle 4 with mul_op=1 and flag_we=4'b1100; a DATA input held during the wait is accepted only in FULL once out_ready=1.
REQ-035 Backpressure: FULL with out_ready=0 for 5 cycles, with a new in_valid present -> outputs stable, in_ready=0, nothing lost; on out_ready=1 both transfers occur in the same cycle.
REQ-036 flush during MUL_WAIT, and rst asserted mid-FULL -> EMPTY, out_valid=0, and the reset values of REQ-028 applied immediately without waiting for clk.
REQ-037 Sweep MUL_CYCLES in {1,2,15} -> out_valid rises exactly MUL_CYCLES cycles after acceptance.
